mc_main_control: RTL and testbench
==================================

// Module: mc_main_control
// PURPOSE
//  Multicycle MIPS-lite main control FSM. Decodes IR opcode, sequences datapath per instruction.
//  Drives aluop1/aluop0 into the ALU control unit, plus all mux selects and write enables.
//  Supports lw, sw, R-type, beq, j. One instruction in flight; no pipelining.
// PARAMETERS
//  OP_RTYPE  6'b000000  R-type opcode
//  OP_LW     6'b100011  load word opcode
//  OP_SW     6'b101011  store word opcode
//  OP_BEQ    6'b000100  branch-equal opcode
//  OP_J      6'b000010  jump opcode
// PORTS
//  clk          in   1  clock; all state updates on rising edge
//  reset        in   1  synchronous, active-high reset
//  op           in   6  opcode field from IR[31:26]; held stable by IR outside FETCH
//  pcwrite      out  1  unconditional PC write enable
//  pcwritecond  out  1  PC write enable, qualified by ALU zero (beq)
//  iord         out  1  memory address select: 0=PC, 1=ALUOut
//  memread      out  1  memory read enable
//  memwrite     out  1  memory write enable
//  irwrite      out  1  IR load enable
//  memtoreg     out  1  regfile write data: 0=ALUOut, 1=MDR
//  regdst       out  1  regfile write address: 0=rt, 1=rd
//  regwrite     out  1  regfile write enable
//  alusrca      out  1  ALU A: 0=PC, 1=reg A
//  alusrcb      out  2  ALU B: 00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  aluop1       out  1  ALU op high bit to ALU control
//  aluop0       out  1  ALU op low bit to ALU control
//  pcsource     out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
//  done         out  1  high in final cycle of each instruction
//  illegal      out  1  high in DECODE when op matches no supported opcode
//  state        out  4  current state encoding, for debug/verification
// BEHAVIOUR
//  State encodings: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 RWB=7 BRANCH=8 JUMP=9.
//  Transitions:
//    FETCH->DECODE.
//    DECODE->MEMADR (lw/sw), EXEC (R-type), BRANCH (beq), JUMP (j), FETCH (other op).
//    MEMADR->MEMRD (lw) or MEMWR (sw).
//    MEMRD->MEMWB; EXEC->RWB.
//    MEMWB, MEMWR, RWB, BRANCH, JUMP -> FETCH.
//  Encodings 10-15 are unreachable; if entered, next state is FETCH and all outputs are 0.
//  Outputs are Moore: a combinational decode of state only (except illegal, which also uses op).
//  Any output not listed for a state is 0:
//    FETCH : memread irwrite pcwrite=1, alusrcb=01, aluop=00, pcsource=00, iord=0, alusrca=0
//    DECODE: alusrca=0, alusrcb=11, aluop=00
//    MEMADR: alusrca=1, alusrcb=10, aluop=00
//    MEMRD : memread=1, iord=1
//    MEMWB : regwrite=1, memtoreg=1, regdst=0, done=1
//    MEMWR : memwrite=1, iord=1, done=1
//    EXEC  : alusrca=1, alusrcb=00, aluop=10
//    RWB   : regwrite=1, regdst=1, memtoreg=0, done=1
//    BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01, done=1
//    JUMP  : pcwrite=1, pcsource=10, done=1
//  Latency in cycles, FETCH inclusive: lw=5, sw=4, R-type=4, beq=3, j=3, illegal=2.
//  Reset: while reset=1, every output except state is forced to 0, overriding the decode.
//  Reset: at the next edge with reset=1, state<=FETCH from any state, including mid-instruction.
//  Reset: first FETCH outputs appear in the cycle after reset deasserts.
//  op is sampled only in DECODE and MEMADR. Changes to op in other states have no effect.
// TESTING
//  reset 2 cycles, op=100011 -> states 0,1,2,3,4 then 0; memread in states 0 and 3; regwrite+memtoreg in 4; done only in 4.
//  op=101011 -> states 0,1,2,5,0; memwrite=1 with iord=1 only in state 5; regwrite never asserted.
//  op=000000 -> states 0,1,6,7,0; aluop=10 in state 6; regwrite=1 and regdst=1 in state 7.
//  op=000100 then op=000010 -> beq: 0,1,8,0 (pcwritecond=1, aluop=01); j: 0,1,9,0 (pcwrite=1, pcsource=10).
//  op=111111 -> illegal=1 in state 1 only; next state 0; no write enables asserted outside FETCH.
//  lw in MEMRD, assert reset 1 cycle -> all outputs 0 that cycle; state=0 next; memwrite/regwrite never pulse.

Source files
------------

// File: rtl/mc_main_control.sv
// Multicycle MIPS-lite main control FSM.
// Decodes the IR opcode and sequences the datapath one instruction at a time
// (lw, sw, R-type, beq, j). Control outputs are a Moore decode of the state
// register. illegal is the exception: it also looks at op, in DECODE only.
// While reset is high, every control output is forced low.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   op[5:0]                    opcode from IR[31:26]
//   pcwrite, pcwritecond       PC write enables (unconditional / zero-qualified)
//   iord, memread, memwrite    memory address select and strobes
//   irwrite                    IR load enable
//   memtoreg, regdst, regwrite register file write controls
//   alusrca, alusrcb[1:0]      ALU operand selects
//   aluop1, aluop0             ALU op to the ALU control unit
//   pcsource[1:0]              PC source select
//   done                       final cycle of an instruction
//   illegal                    unsupported opcode seen in DECODE
//   state[3:0]                 current state encoding (debug)
module mc_main_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       aluop1,
  output logic       aluop0,
  output logic [1:0] pcsource,
  output logic       done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  assign state = cur_state;

  // State register; reset wins from any state, including mid-instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state and Moore output decode; reset masks every output last.
  always_comb begin
    nxt_state   = FETCH;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop1      = 1'b0;
    aluop0      = 1'b0;
    pcsource    = 2'b00;
    done        = 1'b0;
    illegal     = 1'b0;

    case (cur_state)
      FETCH: begin
        memread   = 1'b1;
        irwrite   = 1'b1;
        pcwrite   = 1'b1;
        alusrcb   = 2'b01;
        nxt_state = DECODE;
      end
      DECODE: begin
        // Speculative branch target: PC + (imm << 2).
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: nxt_state = MEMADR;
          OP_RTYPE:     nxt_state = EXEC;
          OP_BEQ:       nxt_state = BRANCH;
          OP_J:         nxt_state = JUMP;
          default: begin
            illegal   = 1'b1;
            nxt_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        nxt_state = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memread   = 1'b1;
        iord      = 1'b1;
        nxt_state = MEMWB;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        done     = 1'b1;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        done     = 1'b1;
      end
      EXEC: begin
        alusrca   = 1'b1;
        aluop1    = 1'b1;
        nxt_state = RWB;
      end
      RWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        done     = 1'b1;
      end
      BRANCH: begin
        alusrca     = 1'b1;
        aluop0      = 1'b1;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        done        = 1'b1;
      end
      JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
        done     = 1'b1;
      end
      default: nxt_state = FETCH;
    endcase

    if (reset) begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regdst      = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      aluop1      = 1'b0;
      aluop0      = 1'b0;
      pcsource    = 2'b00;
      done        = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: walks each instruction class through
// its state sequence and checks the state and every control output per cycle.
module tb_mc_main_control;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, aluop1, aluop0, done, illegal;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  mc_main_control dut (
    .clk(clk), .reset(reset), .op(op),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop1(aluop1), .aluop0(aluop0),
    .pcsource(pcsource), .done(done), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: pcwrite pcwritecond iord memread memwrite irwrite memtoreg
  //              regdst regwrite alusrca alusrcb aluop1 aluop0 pcsource done
  logic [16:0] ctl;
  assign ctl = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                regdst, regwrite, alusrca, alusrcb, aluop1, aluop0, pcsource, done};

  // Hand-written expected control word per state.
  function automatic logic [16:0] exp_ctl(input int s);
    case (s)
      0: exp_ctl = 17'b1_0_0_1_0_1_0_0_0_0_01_0_0_00_0;
      1: exp_ctl = 17'b0_0_0_0_0_0_0_0_0_0_11_0_0_00_0;
      2: exp_ctl = 17'b0_0_0_0_0_0_0_0_0_1_10_0_0_00_0;
      3: exp_ctl = 17'b0_0_1_1_0_0_0_0_0_0_00_0_0_00_0;
      4: exp_ctl = 17'b0_0_0_0_0_0_1_0_1_0_00_0_0_00_1;
      5: exp_ctl = 17'b0_0_1_0_1_0_0_0_0_0_00_0_0_00_1;
      6: exp_ctl = 17'b0_0_0_0_0_0_0_0_0_1_00_1_0_00_0;
      7: exp_ctl = 17'b0_0_0_0_0_0_0_1_1_0_00_0_0_00_1;
      8: exp_ctl = 17'b0_1_0_0_0_0_0_0_0_1_00_0_1_01_1;
      9: exp_ctl = 17'b1_0_0_0_0_0_0_0_0_0_00_0_0_10_1;
      default: exp_ctl = 17'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op    = 6'b100011;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (state !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_state cyc%0d: got %0d expected 0", c, state);
      end
      n_checks++;
      if (ctl !== 17'b0 || illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d: got ctl=%b illegal=%b expected all 0", c, ctl, illegal);
      end
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (ctl !== exp_ctl(0)) begin
      n_fail++;
      $display("FAIL reset_release_fetch: got %b expected %b", ctl, exp_ctl(0));
    end
  endtask

  task automatic test_lw();
    int seq [6] = '{0, 1, 2, 3, 4, 0};
    op = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      n_checks++;
      if (state !== 4'(seq[i])) begin
        n_fail++;
        $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, seq[i]);
      end
      n_checks++;
      if (ctl !== exp_ctl(seq[i]) || illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL lw_ctl[%0d]: got %b/%b expected %b/0", i, ctl, illegal, exp_ctl(seq[i]));
      end
    end
  endtask

  task automatic test_sw();
    int seq [5] = '{0, 1, 2, 5, 0};
    op = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      n_checks++;
      if (state !== 4'(seq[i])) begin
        n_fail++;
        $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, seq[i]);
      end
      n_checks++;
      if (ctl !== exp_ctl(seq[i]) || illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL sw_ctl[%0d]: got %b/%b expected %b/0", i, ctl, illegal, exp_ctl(seq[i]));
      end
    end
  endtask

  // op changes to lw during EXEC; the R-type sequence must be unaffected.
  task automatic test_rtype();
    int seq [5] = '{0, 1, 6, 7, 0};
    op = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      n_checks++;
      if (state !== 4'(seq[i])) begin
        n_fail++;
        $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state, seq[i]);
      end
      n_checks++;
      if (ctl !== exp_ctl(seq[i]) || illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL rtype_ctl[%0d]: got %b/%b expected %b/0", i, ctl, illegal, exp_ctl(seq[i]));
      end
      if (seq[i] == 6) op = 6'b100011;
    end
  endtask

  task automatic test_back_to_back();
    int seq [7] = '{0, 1, 8, 0, 1, 9, 0};
    op = 6'b000100;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      n_checks++;
      if (state !== 4'(seq[i])) begin
        n_fail++;
        $display("FAIL b2b_state[%0d]: got %0d expected %0d", i, state, seq[i]);
      end
      n_checks++;
      if (ctl !== exp_ctl(seq[i]) || illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_ctl[%0d]: got %b/%b expected %b/0", i, ctl, illegal, exp_ctl(seq[i]));
      end
      if (i == 3) op = 6'b000010;
    end
  endtask

  task automatic test_illegal();
    int seq [3] = '{0, 1, 0};
    op = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      n_checks++;
      if (state !== 4'(seq[i])) begin
        n_fail++;
        $display("FAIL illegal_state[%0d]: got %0d expected %0d", i, state, seq[i]);
      end
      n_checks++;
      if (ctl !== exp_ctl(seq[i]) || illegal !== (seq[i] == 1)) begin
        n_fail++;
        $display("FAIL illegal_ctl[%0d]: got %b/%b expected %b/%b", i, ctl, illegal,
                 exp_ctl(seq[i]), (seq[i] == 1));
      end
    end
  endtask

  // Reset asserted for one cycle while lw sits in MEMRD.
  task automatic test_reset_mid();
    op = 6'b100011;
    step();
    step();
    step();
    n_checks++;
    if (state !== 4'd3) begin
      n_fail++;
      $display("FAIL midrst_pre_state: got %0d expected 3", state);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (ctl !== 17'b0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %b/%b expected all 0", ctl, illegal);
    end
    step();
    reset = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL midrst_state: got %0d expected 0", state);
    end
    n_checks++;
    if (ctl !== exp_ctl(0)) begin
      n_fail++;
      $display("FAIL midrst_fetch: got %b expected %b", ctl, exp_ctl(0));
    end
    // Follow the restarted lw to completion; no stale MEMWB should appear early.
    step();
    n_checks++;
    if (state !== 4'd1 || regwrite !== 1'b0 || memwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_decode: got state=%0d rw=%b mw=%b expected 1/0/0", state, regwrite, memwrite);
    end
  endtask

  initial begin
    reset = 1'b1;
    op    = 6'b000000;
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
